fir_seq_ctrl: RTL and testbench

Time-multiplexed FIR controller. It sequences one shared multiply-accumulate unit across TAPS coefficients per input sample, in place of a fully parallel fir_filter datapath. It owns the sample delay line (a circular buffer), the coefficient register file and the valid/ready handshakes on both sides. It sits between the sample source and the downstream consumer of 16-bit filtered data.

---
 rtl/fir_seq_pkg.sv | 29 ++
 rtl/fir_seq_mac.sv | 65 ++++++
 rtl/fir_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - state encoding, default widths and saturation limits for fir_seq_ctrl
package fir_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    localparam int TAPS_DEF = 8;
    localparam int DW_DEF   = 8;
    localparam int CW_DEF   = 8;
    localparam int OW_DEF   = 16;

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    localparam int ACC_W_DEF = DW_DEF + CW_DEF + $clog2(TAPS_DEF);

    function automatic longint sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/fir_seq_mac.sv
// rtl/fir_seq_mac.sv - shared signed MAC with OW reduction; FIR_SEQ_SAT_EN selects saturation over wrap
module fir_seq_mac
    import fir_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int OW = OW_DEF,
    parameter int AW = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] smp,
    input  logic signed [CW-1:0] coef,
    output logic signed [OW-1:0] res
);

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    acc_d;

    always_comb begin
        prod = (DW+CW)'(smp) * (DW+CW)'(coef);
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef FIR_SEQ_SAT_EN
    localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(OW));
    localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(OW));

    // Limits only matter when the accumulator is wider than the output.
    always_comb begin
        res = OW'(acc_q);
        if (AW > OW) begin
            if (acc_q > SAT_HI) begin
                res = OW'(SAT_HI);
            end else if (acc_q < SAT_LO) begin
                res = OW'(SAT_LO);
            end
        end
    end
`else
    always_comb begin
        res = OW'(acc_q);
    end
`endif

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - time-multiplexed FIR controller; optional FIR_SEQ_SAT_EN saturates the result
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int OW   = OW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic signed [DW-1:0]       in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic signed [OW-1:0]       out_data,
    input  logic                       out_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]       coef_data,
    output logic                       busy
);

    localparam int PW = $clog2(TAPS);
    localparam int AW = acc_width(DW, CW, TAPS);
    localparam logic [PW-1:0] K_LAST = PW'(TAPS - 1);

    fir_state_e state_q, state_d;
    logic [PW-1:0] k_q, k_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic signed [DW-1:0] delay_q [TAPS];
    logic signed [DW-1:0] delay_d [TAPS];
    logic signed [CW-1:0] coef_q [TAPS];
    logic signed [CW-1:0] coef_d [TAPS];

    logic accept;
    logic mac_en;
    logic mac_clr;
    logic [PW-1:0] rd_idx;
    logic signed [OW-1:0] mac_res;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        in_ready = (state_q == ST_IDLE) && !clear;
        accept   = in_ready && in_valid;
        if (clear) begin
            state_d  = ST_IDLE;
            k_d      = '0;
            wr_ptr_d = '0;
            mac_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = ST_MAC;
                        k_d     = '0;
                        mac_clr = 1'b1;
                    end
                end
                ST_MAC: begin
                    mac_en = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        k_d      = '0;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The newest sample sits at wr_ptr; tap k looks k samples back.
    always_comb begin
        rd_idx = wr_ptr_q - k_q;
    end

    always_comb begin
        delay_d = delay_q;
        if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_d[i] = '0;
            end
        end else if (accept) begin
            delay_d[wr_ptr_q] = in_data;
        end
    end

    always_comb begin
        coef_d = coef_q;
        if (!clear && (state_q == ST_IDLE) && coef_we) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
            delay_q  <= delay_d;
            coef_q   <= coef_d;
        end
    end

    fir_seq_mac #(
        .DW (DW),
        .CW (CW),
        .OW (OW),
        .AW (AW)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .smp  (delay_q[rd_idx]),
        .coef (coef_q[k_q]),
        .res  (mac_res)
    );

    // A pending clear withdraws the result so it cannot be handshaken away.
    always_comb begin
        out_valid = (state_q == ST_DONE) && !clear;
        out_data  = (state_q == ST_DONE) ? mac_res : '0;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

    localparam int TAPS = 8;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_ready;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               busy;

    fir_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    typedef struct {
        longint exp;
        int     acc_cyc;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_hs_cyc = -1;
    int  last_acc_cyc = -1;
    bit  seen_rise = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency at the rising edge of out_valid, data at the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen_rise = 0;
            end else if (out_valid) begin
                if (!seen_rise) begin
                    seen_rise = 1;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        chk("latency", cyc - sb_q[0].acc_cyc, TAPS + 1);
                    end
                end
                if (out_ready) begin
                    if (sb_q.size() != 0) begin
                        chk("out_data", out_data, sb_q[0].exp);
                        void'(sb_q.pop_front());
                    end
                    last_hs_cyc = cyc;
                    seen_rise = 0;
                end
            end
        end
    end

    task automatic send(input logic signed [7:0] d, input longint e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            sb_q.push_back('{e, cyc});
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input logic signed [7:0] v);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = v;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic longint reduce16(input longint v);
        logic signed [15:0] t;
`ifdef FIR_SEQ_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = v[15:0];
        return t;
`endif
    endfunction

    initial begin
        int n;
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // Coefficients are zero out of reset.
        send(10, 0);
        send(-5, 0);
        drain();

        // All-ones coefficients, constant input builds up the running sum.
        clear_pulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, 1);
        for (int i = 1; i <= 9; i++) send(10, (i > 8) ? 80 : 10 * i);
        drain();

        // Impulse response reproduces the coefficients.
        clear_pulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, 8'(i + 1));
        send(1, 1);
        for (int i = 2; i <= 8; i++) send(0, i);
        send(0, 0);
        drain();

        // Backpressure at DONE.
        clear_pulse();
        out_ready = 1'b0;
        send(1, 1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("hold_reach_done", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0, 2);
        chk("accept_after_handshake", last_acc_cyc, last_hs_cyc + 1);
        drain();

        // Saturation / wrap boundary.
        clear_pulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, 127);
        for (int i = 1; i <= 7; i++) send(127, reduce16(16129 * i));
`ifdef FIR_SEQ_SAT_EN
        send(127, 32767);
`else
        send(127, -2040);
`endif
        drain();

        // clear in the third MAC cycle together with a new sample.
        clear_pulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, 8'(i + 1));
        in_valid = 1'b1;
        in_data  = 7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1; in_valid = 1'b1; in_data = 99;
        @(negedge clk);
        chk("clear_in_ready", in_ready, 0);
        chk("clear_busy_before", busy, 1);
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clear_idle", busy, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("clear_no_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(1, 1);
        send(0, 2);
        drain();

        // Coefficient write during MAC is dropped.
        clear_pulse();
        send(5, 5);
        coef_we = 1'b1; coef_addr = 0; coef_data = 50;
        repeat (2) @(posedge clk);
        #1 coef_we = 1'b0;
        send(0, 10);
        send(3, 18);
        drain();

        // Write and accept in the same IDLE cycle: new coefficient used.
        clear_pulse();
        coef_we = 1'b1; coef_addr = 0; coef_data = 4;
        send(2, 8);
        coef_we = 1'b0;
        drain();

        // Reset mid-MAC.
        send(4, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        send(9, 0);
        send(-3, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
